// File: rtl/cache_ahb_slave_mem.sv
// AHB-Lite SRAM responder with programmable wait states and two-cycle ERROR responses.
// Optional CACHE_SLV_BURST_NOWAIT_EN: SEQ burst beats after an OKAY beat complete with no waits.
module cache_ahb_slave_mem #(
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_hclk,
    input  logic        i_hnreset,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [2:0]  i_hburst,
    input  logic [3:0]  i_hprot,
    input  logic [1:0]  i_htrans,
    input  logic        i_hready,
    input  logic [31:0] i_hwdata,
    output logic        o_hready,
    output logic        o_hresp,
    output logic [31:0] o_hrdata
);

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    localparam logic [3:0] WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e              state_q;
    logic [31:0]         mem [0:(1 << MEM_AW) - 1];
    logic [MEM_AW-1:0]   idx_q;
    logic [1:0]          off_q;
    logic [2:0]          size_q;
    logic                wr_q;
    logic                done_q;     // current cycle is the completing cycle of an OKAY transfer
    logic                last_ok_q;
    logic [3:0]          cnt_q;

    logic                accept;
    logic                bus_err;
    logic                nowait;
    logic                zero_wait;
    logic                commit;
    logic                rd_load;
    logic [MEM_AW-1:0]   bus_idx;
    logic [MEM_AW-1:0]   rd_idx;
    logic [3:0]          wmask;
    logic [31:0]         merged;
    logic [31:0]         rd_word;
    logic                unused_ok;

    assign unused_ok = ^{i_hprot, i_hburst, i_htrans[0]};

    assign bus_idx = i_haddr[MEM_AW+1:2];
    assign accept  = i_hsel & i_hready & i_htrans[1] &
                     ((state_q == StIdle) || (state_q == StErr2));
    assign bus_err = (i_hsize > 3'd2) ||
                     ((i_hsize == 3'd1) && i_haddr[0]) ||
                     ((i_hsize == 3'd2) && (i_haddr[1:0] != 2'b00)) ||
                     ((i_haddr >> (MEM_AW + 2)) != 32'd0);

`ifdef CACHE_SLV_BURST_NOWAIT_EN
    assign nowait = (i_htrans == 2'b11) && (i_hburst != 3'd0) && (state_q == StIdle) &&
                    (done_q || last_ok_q);
`else
    assign nowait = 1'b0;
`endif

    assign zero_wait = (WAIT_CYCLES == 0) || nowait;
    assign commit    = done_q & wr_q;

    always_comb begin
        wmask = 4'b1111;
        case (size_q)
            3'd0:    wmask = 4'b0001 << off_q;
            3'd1:    wmask = off_q[1] ? 4'b1100 : 4'b0011;
            default: wmask = 4'b1111;
        endcase
    end

    always_comb begin
        merged = mem[idx_q];
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) merged[8*b +: 8] = i_hwdata[8*b +: 8];
        end
    end

    // Zero-wait reads sample the array on the accept edge, which may be the commit edge
    // of the preceding write, so forward the merged word.
    always_comb begin
        rd_load = 1'b0;
        rd_idx  = idx_q;
        if (accept && !bus_err && !i_hwrite && zero_wait) begin
            rd_load = 1'b1;
            rd_idx  = bus_idx;
        end else if ((state_q == StWait) && (cnt_q == 4'd0) && !wr_q) begin
            rd_load = 1'b1;
        end
        rd_word = (commit && (idx_q == rd_idx)) ? merged : mem[rd_idx];
    end

    always_ff @(posedge i_hclk) begin
        if (i_hnreset && commit) mem[idx_q] <= merged;
    end

    always_ff @(posedge i_hclk) begin
        if (!i_hnreset) begin
            state_q   <= StIdle;
            o_hready  <= 1'b1;
            o_hresp   <= 1'b0;
            o_hrdata  <= 32'd0;
            cnt_q     <= 4'd0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            last_ok_q <= 1'b0;
            idx_q     <= '0;
            off_q     <= 2'b00;
            size_q    <= 3'd0;
        end else begin
            done_q <= 1'b0;
            if (rd_load) o_hrdata <= rd_word;
            if (done_q) last_ok_q <= 1'b1;
            unique case (state_q)
                StIdle, StErr2: begin
                    state_q  <= StIdle;
                    o_hready <= 1'b1;
                    o_hresp  <= 1'b0;
                    if (accept) begin
                        idx_q  <= bus_idx;
                        off_q  <= i_haddr[1:0];
                        size_q <= i_hsize;
                        wr_q   <= i_hwrite;
                        if (bus_err) begin
                            state_q   <= StErr1;
                            o_hready  <= 1'b0;
                            o_hresp   <= 1'b1;
                            last_ok_q <= 1'b0;
                        end else if (zero_wait) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= StWait;
                            cnt_q    <= WaitInit;
                            o_hready <= 1'b0;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= StIdle;
                        o_hready <= 1'b1;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StErr1: begin
                    state_q  <= StErr2;
                    o_hready <= 1'b1;
                    o_hresp  <= 1'b1;
                end
                default: begin
                    state_q  <= StIdle;
                    o_hready <= 1'b1;
                    o_hresp  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ahb_slave_mem.sv
// Directed bench for cache_ahb_slave_mem: three instances with 2, 0 and 3 wait states.
module tb_cache_ahb_slave_mem;

`ifdef CACHE_SLV_BURST_NOWAIT_EN
    localparam bit NoWait = 1'b1;
`else
    localparam bit NoWait = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          sel = 0;
    logic        hsel_g = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] hwdata = 32'd0;
    logic [2:0]  rdy;
    logic [2:0]  rsp;
    logic [31:0] rdt [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cache_ahb_slave_mem #(.MEM_AW(8), .WAIT_CYCLES(2)) u_w2 (
        .i_hclk(clk), .i_hnreset(rst_n), .i_hsel(hsel_g && sel == 0), .i_haddr(haddr),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(4'd0),
        .i_htrans(htrans), .i_hready(rdy[0]), .i_hwdata(hwdata),
        .o_hready(rdy[0]), .o_hresp(rsp[0]), .o_hrdata(rdt[0])
    );
    cache_ahb_slave_mem #(.MEM_AW(8), .WAIT_CYCLES(0)) u_w0 (
        .i_hclk(clk), .i_hnreset(rst_n), .i_hsel(hsel_g && sel == 1), .i_haddr(haddr),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(4'd0),
        .i_htrans(htrans), .i_hready(rdy[1]), .i_hwdata(hwdata),
        .o_hready(rdy[1]), .o_hresp(rsp[1]), .o_hrdata(rdt[1])
    );
    cache_ahb_slave_mem #(.MEM_AW(8), .WAIT_CYCLES(3)) u_w3 (
        .i_hclk(clk), .i_hnreset(rst_n), .i_hsel(hsel_g && sel == 2), .i_haddr(haddr),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(4'd0),
        .i_htrans(htrans), .i_hready(rdy[2]), .i_hwdata(hwdata),
        .o_hready(rdy[2]), .o_hresp(rsp[2]), .o_hrdata(rdt[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer; returns during its completing cycle so the next call overlaps it.
    task automatic xfer(input int s, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata, input int exp_waits,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
        int n;
        sel = s; hsel_g = 1'b1; htrans = 2'b10; hburst = 3'd0;
        haddr = addr; hwrite = wr; hsize = size;
        step();
        hsel_g = 1'b0; htrans = 2'b00; hwdata = wdata;
        n = 0;
        while (rdy[sel] !== 1'b1 && n < 20) begin
            chk({tag, "_wresp"}, {31'd0, rsp[sel]}, {31'd0, exp_err});
            step();
            n++;
        end
        chk({tag, "_waits"}, 32'(n), 32'(exp_waits));
        chk({tag, "_resp"}, {31'd0, rsp[sel]}, {31'd0, exp_err});
        chk({tag, "_rdata"}, rdt[sel], exp_rd);
    endtask

    initial begin
        int n;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", {31'd0, rdy[i]}, 32'd1);
            chk("rst_resp", {31'd0, rsp[i]}, 32'd0);
            chk("rst_rdata", rdt[i], 32'd0);
        end
        rst_n = 1'b1;
        step();

        // Word write/read with two wait states each
        xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 2, 1'b0, 32'd0, "t1_wr");
        xfer(0, 1'b0, 32'h10, 3'd2, 32'd0, 2, 1'b0, 32'hDEADBEEF, "t1_rd");

        // Lane merges; o_hrdata holds across writes
        xfer(0, 1'b1, 32'h10, 3'd2, 32'h11223344, 2, 1'b0, 32'hDEADBEEF, "t2_wr");
        xfer(0, 1'b1, 32'h11, 3'd0, 32'h0000AA00, 2, 1'b0, 32'hDEADBEEF, "t2_wb");
        xfer(0, 1'b0, 32'h10, 3'd2, 32'd0, 2, 1'b0, 32'h1122AA44, "t2_rd");
        xfer(0, 1'b1, 32'h12, 3'd1, 32'hBEEF0000, 2, 1'b0, 32'h1122AA44, "t2_wh");
        xfer(0, 1'b0, 32'h10, 3'd2, 32'd0, 2, 1'b0, 32'hBEEFAA44, "t2_rh");

        // Error responses, back-to-back from ERR2, array untouched
        xfer(0, 1'b0, 32'h2, 3'd2, 32'd0, 1, 1'b1, 32'hBEEFAA44, "t3_mis");
        xfer(0, 1'b0, 32'h10000, 3'd2, 32'd0, 1, 1'b1, 32'hBEEFAA44, "t3_oor");
        xfer(0, 1'b1, 32'h10010, 3'd2, 32'd0, 1, 1'b1, 32'hBEEFAA44, "t3_woor");
        xfer(0, 1'b1, 32'h11, 3'd1, 32'd0, 1, 1'b1, 32'hBEEFAA44, "t3_whodd");
        xfer(0, 1'b1, 32'h10, 3'd3, 32'd0, 1, 1'b1, 32'hBEEFAA44, "t3_wsz");
        xfer(0, 1'b0, 32'h10, 3'd2, 32'd0, 2, 1'b0, 32'hBEEFAA44, "t3_rd");

        // BUSY with select gets a zero-wait OKAY
        sel = 0; hsel_g = 1'b1; htrans = 2'b01; haddr = 32'h14;
        step();
        hsel_g = 1'b0; htrans = 2'b00;
        chk("busy_ready", {31'd0, rdy[0]}, 32'd1);
        chk("busy_resp", {31'd0, rsp[0]}, 32'd0);

        // Zero wait states with write-to-read forwarding
        xfer(1, 1'b1, 32'h20, 3'd2, 32'h5, 0, 1'b0, 32'd0, "t4_wr");
        xfer(1, 1'b0, 32'h20, 3'd2, 32'd0, 0, 1'b0, 32'h5, "t4_fwd");
        xfer(1, 1'b1, 32'h24, 3'd2, 32'h11223344, 0, 1'b0, 32'h5, "t4_wr2");
        xfer(1, 1'b1, 32'h27, 3'd0, 32'h99000000, 0, 1'b0, 32'h5, "t4_wb");
        xfer(1, 1'b0, 32'h24, 3'd2, 32'd0, 0, 1'b0, 32'h99223344, "t4_fwdb");
        xfer(1, 1'b0, 32'h20, 3'd2, 32'd0, 0, 1'b0, 32'h5, "t4_rd");

        // Reset during a wait state drops the pending write
        xfer(0, 1'b1, 32'h30, 3'd2, 32'd0, 2, 1'b0, 32'hBEEFAA44, "t5_wr0");
        sel = 0; hsel_g = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
        step();
        hsel_g = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
        chk("t5_inwait", {31'd0, rdy[0]}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_rst_ready", {31'd0, rdy[0]}, 32'd1);
        chk("t5_rst_resp", {31'd0, rsp[0]}, 32'd0);
        chk("t5_rst_rdata", rdt[0], 32'd0);
        step();
        step();
        chk("t5_idle_ready", {31'd0, rdy[0]}, 32'd1);
        xfer(0, 1'b0, 32'h30, 3'd2, 32'd0, 2, 1'b0, 32'd0, "t5_rd");
        xfer(0, 1'b0, 32'h10, 3'd2, 32'd0, 2, 1'b0, 32'hBEEFAA44, "t5_keep");

        // INCR4 read burst, three wait states on the NONSEQ beat
        for (int k = 0; k < 4; k++)
            xfer(2, 1'b1, 32'h40 + 32'(4 * k), 3'd2, 32'h40000000 + 32'(k), 3, 1'b0, 32'd0,
                 "t6_pre");
        sel = 2; hsel_g = 1'b1; htrans = 2'b10; hburst = 3'b011;
        haddr = 32'h40; hwrite = 1'b0; hsize = 3'd2;
        step();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                htrans = 2'b11;
                haddr = 32'h40 + 32'(4 * (k + 1));
            end else begin
                hsel_g = 1'b0;
                htrans = 2'b00;
            end
            n = 0;
            while (rdy[2] !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            chk("t6_waits", 32'(n), (k == 0 || !NoWait) ? 32'd3 : 32'd0);
            chk("t6_resp", {31'd0, rsp[2]}, 32'd0);
            chk("t6_rdata", rdt[2], 32'h40000000 + 32'(k));
            step();
        end
        hburst = 3'd0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ahb_slave_mem.md
Name: cache_ahb_slave_mem

Overview:
- AHB-Lite read/write SRAM responder for the cache's outbound AHB master path. It stands in for, or sits beside, the SPIFI memory port as a fast backing store and a bench target.
- Implements the full address/data phase pipeline, programmable wait states and two-cycle ERROR responses.
- Holds 2**MEM_AW 32-bit words internally.

Parameters:
- MEM_AW, 8: word-address width; array depth is 2**MEM_AW words.
- WAIT_CYCLES, 2: wait states (o_hready low) inserted per data phase; legal range 0..15.

Ports:
- i_hclk  in  1  clock, rising-edge.
- i_hnreset  in  1  reset, synchronous, active-low.
- i_hsel  in  1  slave select.
- i_haddr  in  32  byte address.
- i_hwrite  in  1  1 = write.
- i_hsize  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
- i_hburst  in  3  burst type; ignored except under the optional feature.
- i_hprot  in  4  ignored.
- i_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- i_hready  in  1  bus HREADY (previous transfer complete).
- i_hwdata  in  32  write data, valid in data phase.
- o_hready  out  1  HREADYOUT.
- o_hresp  out  1  0 = OKAY, 1 = ERROR.
- o_hrdata  out  32  read data, valid when o_hready=1 in a read data phase.

Behaviour:
- Reset (i_hnreset=0 sampled at a rising edge): state IDLE, o_hready=1, o_hresp=0, o_hrdata=0, wait counter=0, pending-write flag cleared.
- Array contents are not reset.
- Address phase is accepted when i_hsel & i_hready & i_htrans[1] are all 1.
  - Captured into registers: word index haddr[MEM_AW+1:2], byte offset haddr[1:0], hsize, hwrite.
  - IDLE and BUSY transfers get a zero-wait OKAY response and cause no access.
- An accepted transfer is an error when any of these holds:
  - hsize > 2;
  - hsize=1 with haddr[0]=1;
  - hsize=2 with haddr[1:0] != 0;
  - haddr[31:MEM_AW+2] != 0.
- State machine:
  - IDLE: on an accepted transfer, go to ERR1 if it is an error; else go to WAIT if WAIT_CYCLES>0; else stay in IDLE and complete the transfer with o_hready=1 in the next cycle.
  - WAIT: o_hready=0, o_hresp=0. Counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At 0, the next cycle is the completing cycle (o_hready=1, OKAY), then the FSM returns to IDLE. It may also accept a new transfer in that same completing cycle.
  - ERR1: o_hready=0, o_hresp=1. Always goes to ERR2.
  - ERR2: o_hready=1, o_hresp=1. Goes to IDLE, and may accept a new address phase in the same cycle. No array access occurs for an errored transfer.
- Read data: o_hrdata is registered and loaded from the array one cycle before the completing cycle.
  - Byte and half reads return the full aligned word; the master selects lanes.
  - Outside a completing read, o_hrdata holds its last value.
- Write: i_hwdata is sampled in the completing cycle and committed at that edge.
  - Only lanes selected by hsize/offset are written: byte lane = offset; half lanes = offset[1] pair; word = all four.
- Back-to-back hazard: a read whose address phase coincides with the commit of a write to the same word returns the merged new data (forwarding required).
- Reset mid-transfer: the transfer is abandoned, the pending write is dropped, and the FSM returns to IDLE.
- Wait counter width is 4 bits.

Optional Feature:
- CACHE_SLV_BURST_NOWAIT_EN defined: SEQ transfers inside an INCR/INCR4/WRAP4 burst (i_hburst != 0) that follow an OKAY beat complete with zero wait states. NONSEQ beats still take WAIT_CYCLES.
- Not defined: every transfer takes WAIT_CYCLES wait states regardless of htrans/hburst.

Test Plan:
1. Word write 0xDEADBEEF to 0x0000_0010, then word read 0x10 with WAIT_CYCLES=2 -> each data phase shows 2 cycles o_hready=0, then o_hready=1 with o_hrdata=0xDEADBEEF and o_hresp=0.
2. Byte write 0xAA to 0x11 over word 0x11223344 at 0x10, then read 0x10 -> 0x1122AA44.
3. Word read at 0x0000_0002 and word read at 0x0001_0000 (MEM_AW=8) -> each gets ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); array unchanged.
4. WAIT_CYCLES=0: write 0x5 to 0x20 immediately followed by read 0x20 -> read completes next cycle with 0x00000005 via forwarding.
5. i_hnreset low for one cycle during WAIT -> o_hready=1 and o_hresp=0 next cycle; the pending write to 0x30 does not occur (the previously written 0x0 reads back).
6. CACHE_SLV_BURST_NOWAIT_EN, INCR4 read from 0x40, WAIT_CYCLES=3 -> beat 0 takes 3 waits; beats 1..3 complete in consecutive cycles.
